// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready command stream into
// AXI4-Lite reads and writes and returns exactly one response per command.
module axi4lite_cmd_master #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int unsigned CNT_W        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_c;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_d, wdata_d;
  logic [1:0]        rsp_resp_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic              awvalid_d, wvalid_d, wstrb_d, bready_d, arvalid_d, rready_d;

  logic accept_c, aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, rsp_hs_c;
  logic wr_both_c, expire_c;

  assign accept_c  = cmd_valid & cmd_ready;
  assign aw_hs_c   = m_axi_awvalid & m_axi_awready;
  assign w_hs_c    = m_axi_wvalid & m_axi_wready;
  assign b_hs_c    = m_axi_bvalid & m_axi_bready;
  assign ar_hs_c   = m_axi_arvalid & m_axi_arready;
  assign r_hs_c    = m_axi_rvalid & m_axi_rready;
  assign rsp_hs_c  = rsp_valid & rsp_ready;
  assign wr_both_c = (aw_done_q | aw_hs_c) & (w_done_q | w_hs_c);

  // Watchdog fires on the last allowed cycle; the count saturates instead of wrapping.
  assign expire_c  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State and output registers
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_write     <= rsp_write_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept_c) state_d = cmd_write ? WR : RD_AR;
      WR:    if (wr_both_c) state_d = WR_B;
             else if (expire_c) state_d = RSP;
      WR_B:  if (b_hs_c || expire_c) state_d = RSP;
      RD_AR: if (ar_hs_c) state_d = RD_R;
             else if (expire_c) state_d = RSP;
      RD_R:  if (r_hs_c || expire_c) state_d = RSP;
      RSP:   if (rsp_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed below
  always_comb begin
    cnt_d       = cnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    awaddr_d    = m_axi_awaddr;
    awvalid_d   = m_axi_awvalid;
    wdata_d     = m_axi_wdata;
    wstrb_d     = m_axi_wstrb;
    wvalid_d    = m_axi_wvalid;
    bready_d    = m_axi_bready;
    araddr_d    = m_axi_araddr;
    arvalid_d   = m_axi_arvalid;
    rready_d    = m_axi_rready;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        cnt_d = cnt_inc_c;
        if (aw_hs_c) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs_c) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (wr_both_c) begin
          bready_d = 1'b1;
        end else if (expire_c) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = RESP_TIMEOUT;
        end
      end
      WR_B: begin
        cnt_d = cnt_inc_c;
        if (b_hs_c || expire_c) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = b_hs_c ? m_axi_bresp : RESP_TIMEOUT;
        end
      end
      RD_AR: begin
        cnt_d = cnt_inc_c;
        if (ar_hs_c) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expire_c) begin
          arvalid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = RESP_TIMEOUT;
        end
      end
      RD_R: begin
        cnt_d = cnt_inc_c;
        if (r_hs_c || expire_c) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = r_hs_c ? m_axi_rdata : '0;
          rsp_resp_d  = r_hs_c ? m_axi_rresp : RESP_TIMEOUT;
        end
      end
      RSP: begin
        if (rsp_hs_c) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that converts a simple valid/ready command stream into AXI4-Lite read and write transactions.
- Sits directly upstream of the 8-bit, 2-bit-address register-file slave and drives all five of its channels.
- Returns one response per command on a valid/ready response stream.
- A watchdog aborts transactions whose slave handshake never completes.

Parameters:
- ADDR_W, 2, AXI address width (matches slave awaddr/araddr)
- DATA_W, 8, AXI data width (matches slave wdata/rdata)
- TIMEOUT, 16, cycles allowed per transaction before abort; 0 disables the watchdog

Ports:
- m_axi_aclk  in  1  clock
- m_axi_areset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master idle, accepts command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI resp, or 2'b11 on timeout
- m_axi_awaddr out ADDR_W; m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata out DATA_W; m_axi_wstrb out 1; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
- m_axi_araddr out ADDR_W; m_axi_arvalid out 1; m_axi_arready in 1
- m_axi_rdata in DATA_W; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1

Behaviour:
- One clock (m_axi_aclk); reset is synchronous and active-high (m_axi_areset). All outputs are registered.
- Reset values:
  - all valid/ready outputs 0, except cmd_ready=1;
  - all address/data/resp outputs 0; timeout counter 0; state IDLE.
- States: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready=1. On cmd_valid&&cmd_ready, latch the command and drop cmd_ready.
  - Write: next cycle assert awvalid and wvalid together, wstrb=1 -> WR.
  - Read: assert arvalid -> RD_AR.
- WR:
  - awvalid and wvalid are tracked independently.
  - Each is deasserted on the edge where its own ready is sampled high, and a done flag is set for it.
  - Address and data are held stable while the corresponding valid is high.
  - When both flags are set (same cycle allowed), assert bready -> WR_B.
- WR_B: on bvalid&&bready, capture bresp, drop bready, rsp_write=1, rsp_rdata=0 -> RSP.
- RD_AR: hold arvalid until arready is sampled high; then drop arvalid, assert rready -> RD_R.
- RD_R: on rvalid&&rready, capture rdata/rresp, drop rready, rsp_write=0 -> RSP.
- RSP: rsp_valid=1 with fields stable until rsp_ready. On the handshake, rsp_valid=0, cmd_ready=1 -> IDLE.
- Valid and ready signals never deassert before their handshake (except on timeout or reset).
- Watchdog:
  - Counter clears on command accept and increments every cycle in WR/WR_B/RD_AR/RD_R.
  - At count==TIMEOUT-1 with the handshake still pending: deassert every AXI valid/ready, rsp_resp=2'b11, rsp_rdata=0 -> RSP.
  - Any beat arriving later is ignored; bready/rready stay 0 outside WR_B/RD_R.
- The counter saturates and never wraps.
- Minimum latency against a zero-wait slave:
  - Write: cmd handshake to rsp_valid in 4 cycles.
  - Read: cmd handshake to rsp_valid in 4 cycles.
  - The slave's registered-ready timing (awready one cycle after awvalid, wready one cycle after address capture) must be tolerated.
- Only one command is outstanding; cmd_ready=0 from accept until the RSP handshake.
- Reset mid-transaction returns the block to IDLE immediately and drops all valids. No response is generated.

Test Plan:
- Write addr=2, data=0xA5 to the slave model, rsp_ready=1 -> one AW and one W handshake; bready seen; rsp_valid with rsp_write=1, rsp_resp=00; slave reg[2]=0xA5.
- Read addr=2 after the previous write -> one AR handshake; rsp_rdata=0xA5, rsp_resp=00, rsp_write=0.
- Slave model asserts wready 3 cycles before awready -> wvalid drops first, awvalid held with awaddr stable; single B handshake; response OKAY.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp fields stable; cmd_ready=0 throughout; new cmd_valid is not accepted until the rsp handshake.
- TIMEOUT=16, slave never asserts arready -> arvalid drops after 16 cycles; rsp_resp=11, rsp_rdata=0; a late rvalid is ignored.
- Assert m_axi_areset while in WR_B -> next cycle all AXI valid/ready=0, cmd_ready=1, rsp_valid=0.
